frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320, meaning visible columns.
REQ-002 SHALL have parameter SCREEN_H, default 240, meaning visible rows.
REQ-003 SHALL have parameter SKY_COLOR, default 3'd6, meaning clear-pass fill colour.
REQ-004 SHALL have port Clk  input  1  system clock, all flops on rising edge.
REQ-005 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port vsync  input  1  vertical-blank level from VGA controller.
REQ-007 SHALL have port player_pos_in  input  posXY  live player position.
REQ-008 SHALL have port player_angle_in  input  angle  live player angle.
REQ-009 SHALL have port player_pos  output  posXY  per-frame latched position to renderer.
REQ-010 SHALL have port player_angle  output  angle  per-frame latched angle to renderer.
REQ-011 SHALL have port render_ack  output  1  one-cycle frame-start pulse to renderer.
REQ-012 SHALL have port render_done  input  1  one-cycle frame-complete pulse from renderer.
REQ-013 SHALL have ports render_coords/render_color/render_we  input  screenXY/3/1  renderer pixel write.
REQ-014 SHALL have ports fb_coords/fb_color/fb_we  output  screenXY/3/1  framebuffer write port.
REQ-015 SHALL have port back_buf  output  1  buffer currently written; front buffer is ~back_buf.
REQ-016 SHALL have port frame_count  output  16  completed-swap counter.

Function
REQ-017 States SHALL be IDLE, CLEAR, KICK, RENDERING, WAIT_VBLANK, SWAP.
REQ-018 IDLE -> CLEAR (macro on) or KICK (macro off) unconditionally next cycle.
REQ-019 KICK: render_ack=1 exactly one cycle; player_pos/player_angle latched from *_in on that same edge and held constant until next KICK; -> RENDERING.
REQ-020 RENDERING: fb_coords/fb_color/fb_we = render_* registered, latency exactly 1 cycle; -> WAIT_VBLANK on render_done=1.
REQ-021 Render writes arriving outside RENDERING SHALL be dropped (fb_we=0).
REQ-022 WAIT_VBLANK: -> SWAP on vsync rising edge (registered previous vsync, 0->1); fb_we=0.
REQ-023 render_done and vsync rising edge in same RENDERING cycle: edge ignored, swap waits for next rising edge.
REQ-024 SWAP (one cycle): back_buf toggles, frame_count increments modulo 2^16 (0xFFFF -> 0x0000); -> CLEAR or KICK per REQ-018.
REQ-025 render_ack SHALL never be asserted outside KICK; at most one render_ack per swap.
REQ-026 No timeout: RENDERING waits indefinitely for render_done.

Reset
REQ-027 Reset_n=0 SHALL immediately force state IDLE, render_ack=0, fb_we=0, fb_coords=0, fb_color=0, back_buf=0, frame_count=0, player_pos=0, player_angle=0, vsync history=0.
REQ-028 Reset mid-frame SHALL abandon the frame with no swap; deassertion restarts at IDLE.

Configuration
REQ-029 Macro FRAME_SEQ_CLEAR_EN defined: CLEAR writes SKY_COLOR to every pixel of back_buf, raster order x 0..SCREEN_W-1 inner, y 0..SCREEN_H-1 outer, one pixel/cycle, fb_we=1 throughout, exactly SCREEN_W*SCREEN_H cycles, then -> KICK.
REQ-030 Macro undefined: CLEAR state and its counters absent; IDLE/SWAP go directly to KICK.

Structure
REQ-031 screenXY, posXY, angle typedefs, SCREEN_W/SCREEN_H constants and the state enum SHALL live in the shared structs package.
REQ-032 Clear raster counter SHALL be sub-module fb_clear_scanner (start in; coords, we, done out), instantiated only under FRAME_SEQ_CLEAR_EN.

Verification
REQ-033 Reset release, macro off: render_ack pulses 1 cycle at cycle 2; player_pos equals player_pos_in sampled at that edge, stable while player_pos_in changes.
REQ-034 render_we=1, coords (10,20), color 5 during RENDERING -> fb_we=1, fb_coords (10,20), fb_color 5 one cycle later; same stimulus in WAIT_VBLANK -> fb_we=0.
REQ-035 render_done then vsync 0->1 after 100 cycles -> back_buf 0->1, frame_count 0->1, render_ack one cycle after SWAP.
REQ-036 render_done coincident with vsync rise -> no swap; swap on following vsync rise.
REQ-037 Macro on: 76800 consecutive fb_we cycles, first (0,0), last (319,239), color 3'd6, then render_ack.
REQ-038 Preload frame_count 0xFFFF via 65535 swaps (or force) -> next swap gives 0x0000; Reset_n low mid-RENDERING -> all REQ-027 values same cycle, back_buf unchanged=0.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// Shared types, screen constants and sequencer state encoding for the frame sequencer.
package frame_sequencer_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W      = $clog2(SCREEN_W);
  localparam int Y_W      = $clog2(SCREEN_H);

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } screenXY;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } posXY;

  typedef logic [7:0] angle;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    KICK,
    RENDERING,
    WAIT_VBLANK,
    SWAP
  } seq_state_e;

  // Off-screen renderer writes would alias into the framebuffer address space.
  function automatic logic on_screen(input screenXY c, input int w, input int h);
    return (int'(c.x) < w) && (int'(c.y) < h);
  endfunction

endpackage

// File: rtl/fb_clear_scanner.sv
// Raster scanner for the sky-fill pass: one pixel per cycle, x inner, y outer.
module fb_clear_scanner
  import frame_sequencer_pkg::*;
#(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic    Clk,
  input  logic    Reset_n,
  input  logic    start,
  output screenXY coords,
  output logic    we,
  output logic    done
);

  logic [X_W-1:0] x_p0;
  logic [Y_W-1:0] y_p0;
  logic           vld_p0;
  logic           last_x;
  logic           last_y;

  assign last_x = (x_p0 == X_W'(SCREEN_W - 1));
  assign last_y = (y_p0 == Y_W'(SCREEN_H - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p0 <= 1'b0;
      x_p0   <= '0;
      y_p0   <= '0;
    end else if (start) begin
      vld_p0 <= 1'b1;
      x_p0   <= '0;
      y_p0   <= '0;
    end else if (vld_p0) begin
      if (last_x) begin
        x_p0 <= '0;
        if (last_y) begin
          vld_p0 <= 1'b0;
          y_p0   <= '0;
        end else begin
          y_p0 <= y_p0 + 1'b1;
        end
      end else begin
        x_p0 <= x_p0 + 1'b1;
      end
    end
  end

  assign coords = {x_p0, y_p0};
  assign we     = vld_p0;
  assign done   = vld_p0 & last_x & last_y;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame sequencer: latches player state, gates renderer writes and swaps buffers on vblank.
// Optional sky-fill pass before each frame is built when FRAME_SEQ_CLEAR_EN is defined.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int         SCREEN_W  = 320,
  parameter int         SCREEN_H  = 240,
  parameter logic [2:0] SKY_COLOR = 3'd6
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        vsync,
  input  posXY        player_pos_in,
  input  angle        player_angle_in,
  output posXY        player_pos,
  output angle        player_angle,
  output logic        render_ack,
  input  logic        render_done,
  input  screenXY     render_coords,
  input  logic [2:0]  render_color,
  input  logic        render_we,
  output screenXY     fb_coords,
  output logic [2:0]  fb_color,
  output logic        fb_we,
  output logic        back_buf,
  output logic [15:0] frame_count
);

  seq_state_e state;
  seq_state_e state_nxt;
  logic       vsync_p1;
  logic       vsync_rise;
  screenXY    fb_coords_p1;
  logic [2:0] fb_color_p1;
  logic       vld_p1;

  assign vsync_rise = vsync & ~vsync_p1;

`ifdef FRAME_SEQ_CLEAR_EN
  localparam seq_state_e FRAME_START = CLEAR;

  screenXY scan_coords;
  logic    scan_we;
  logic    scan_done;
  logic    scan_start;

  assign scan_start = (state != CLEAR) && (state_nxt == CLEAR);

  fb_clear_scanner #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clear (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (scan_start),
    .coords  (scan_coords),
    .we      (scan_we),
    .done    (scan_done)
  );

  // The scanner counters are already registered, so the fill drives the port directly.
  assign fb_we     = (state == CLEAR) ? scan_we     : vld_p1;
  assign fb_coords = (state == CLEAR) ? scan_coords : fb_coords_p1;
  assign fb_color  = (state == CLEAR) ? SKY_COLOR   : fb_color_p1;
`else
  localparam seq_state_e FRAME_START = KICK;

  assign fb_we     = vld_p1;
  assign fb_coords = fb_coords_p1;
  assign fb_color  = fb_color_p1;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:        state_nxt = FRAME_START;
`ifdef FRAME_SEQ_CLEAR_EN
      CLEAR:       if (scan_done) state_nxt = KICK;
`endif
      KICK:        state_nxt = RENDERING;
      RENDERING:   if (render_done) state_nxt = WAIT_VBLANK;
      WAIT_VBLANK: if (vsync_rise) state_nxt = SWAP;
      SWAP:        state_nxt = FRAME_START;
      default:     state_nxt = IDLE;
    endcase
  end

  // A vsync edge coinciding with render_done is seen in RENDERING and therefore ignored.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      vsync_p1     <= 1'b0;
      render_ack   <= 1'b0;
      player_pos   <= '0;
      player_angle <= '0;
      back_buf     <= 1'b0;
      frame_count  <= 16'd0;
    end else begin
      state      <= state_nxt;
      vsync_p1   <= vsync;
      render_ack <= (state_nxt == KICK);
      if (state_nxt == KICK) begin
        player_pos   <= player_pos_in;
        player_angle <= player_angle_in;
      end
      if (state == SWAP) begin
        back_buf    <= ~back_buf;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Renderer write pipeline: one register stage, writes only accepted while RENDERING.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p1       <= 1'b0;
      fb_coords_p1 <= '0;
      fb_color_p1  <= '0;
    end else begin
      vld_p1       <= (state == RENDERING) && render_we
                      && on_screen(render_coords, SCREEN_W, SCREEN_H);
      fb_coords_p1 <= render_coords;
      fb_color_p1  <= render_color;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: reset, kick/latch, write gating, swaps, wrap and mid-frame reset.
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;

`ifdef FRAME_SEQ_CLEAR_EN
  localparam int CLR_CYC = 320 * 240;
`else
  localparam int CLR_CYC = 0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        vsync = 1'b0;
  posXY        player_pos_in;
  angle        player_angle_in;
  posXY        player_pos;
  angle        player_angle;
  logic        render_ack;
  logic        render_done = 1'b0;
  screenXY     render_coords;
  logic [2:0]  render_color;
  logic        render_we = 1'b0;
  screenXY     fb_coords;
  logic [2:0]  fb_color;
  logic        fb_we;
  logic        back_buf;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;

  posXY pos_a, pos_b;
  screenXY exp_c;

  always #5 Clk = ~Clk;

  frame_sequencer dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .vsync           (vsync),
    .player_pos_in   (player_pos_in),
    .player_angle_in (player_angle_in),
    .player_pos      (player_pos),
    .player_angle    (player_angle),
    .render_ack      (render_ack),
    .render_done     (render_done),
    .render_coords   (render_coords),
    .render_color    (render_color),
    .render_we       (render_we),
    .fb_coords       (fb_coords),
    .fb_color        (fb_color),
    .fb_we           (fb_we),
    .back_buf        (back_buf),
    .frame_count     (frame_count)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    player_pos_in   = '{x: 16'sd0, y: 16'sd0};
    player_angle_in = 8'd0;
    render_coords   = '{x: 9'd0, y: 8'd0};
    render_color    = 3'd0;
    step();
    step();
    checks++; if (render_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", render_ack); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we: got %b want 0", fb_we); end
    checks++; if (fb_coords !== 17'h0) begin errors++; $display("FAIL reset_fb_coords: got %h want 0", fb_coords); end
    checks++; if (fb_color !== 3'd0) begin errors++; $display("FAIL reset_fb_color: got %0d want 0", fb_color); end
    checks++; if (back_buf !== 1'b0) begin errors++; $display("FAIL reset_back_buf: got %b want 0", back_buf); end
    checks++; if (frame_count !== 16'h0) begin errors++; $display("FAIL reset_frame_count: got %h want 0", frame_count); end
    checks++; if (player_pos !== 32'h0) begin errors++; $display("FAIL reset_player_pos: got %h want 0", player_pos); end
    checks++; if (player_angle !== 8'h0) begin errors++; $display("FAIL reset_player_angle: got %h want 0", player_angle); end
  endtask

  task automatic test_kick();
    int bad;
    pos_a = '{x: 16'sd100, y: -16'sd50};
    pos_b = '{x: 16'sd7, y: 16'sd9};
    player_pos_in   = pos_a;
    player_angle_in = 8'd45;
    Reset_n = 1'b1;
    checks++; if (render_ack !== 1'b0) begin errors++; $display("FAIL kick_ack_cycle1: got %b want 0", render_ack); end
    step();
`ifdef FRAME_SEQ_CLEAR_EN
    bad = 0;
    for (int y = 0; y < 240; y++) begin
      for (int x = 0; x < 320; x++) begin
        if (fb_we !== 1'b1 || fb_coords.x !== 9'(x) || fb_coords.y !== 8'(y) || fb_color !== 3'd6 || render_ack !== 1'b0)
          bad++;
        step();
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_stream: got %0d bad pixels want 0", bad); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL clear_end_we: got %b want 0", fb_we); end
`else
    bad = 0;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL kick_no_fill: got %b want 0", fb_we); end
`endif
    checks++; if (render_ack !== 1'b1) begin errors++; $display("FAIL kick_ack: got %b want 1", render_ack); end
    checks++; if (player_pos !== pos_a) begin errors++; $display("FAIL kick_pos: got %h want %h", player_pos, pos_a); end
    checks++; if (player_angle !== 8'd45) begin errors++; $display("FAIL kick_angle: got %0d want 45", player_angle); end
    player_pos_in   = pos_b;
    player_angle_in = 8'd200;
    step();
    checks++; if (render_ack !== 1'b0) begin errors++; $display("FAIL kick_ack_one_cycle: got %b want 0", render_ack); end
    checks++; if (player_pos !== pos_a) begin errors++; $display("FAIL kick_pos_held: got %h want %h", player_pos, pos_a); end
    checks++; if (player_angle !== 8'd45) begin errors++; $display("FAIL kick_angle_held: got %0d want 45", player_angle); end
  endtask

  task automatic test_render_writes();
    render_coords = '{x: 9'd10, y: 8'd20};
    render_color  = 3'd5;
    render_we     = 1'b1;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL wr_latency_early: got %b want 0", fb_we); end
    step();
    exp_c = '{x: 9'd10, y: 8'd20};
    checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b want 1", fb_we); end
    checks++; if (fb_coords !== exp_c) begin errors++; $display("FAIL wr_coords: got %h want %h", fb_coords, exp_c); end
    checks++; if (fb_color !== 3'd5) begin errors++; $display("FAIL wr_color: got %0d want 5", fb_color); end
    render_coords = '{x: 9'd319, y: 8'd239};
    render_color  = 3'd2;
    step();
    exp_c = '{x: 9'd319, y: 8'd239};
    checks++; if (fb_coords !== exp_c || fb_color !== 3'd2 || fb_we !== 1'b1) begin errors++; $display("FAIL wr_corner: got %h/%0d/%b want %h/2/1", fb_coords, fb_color, fb_we, exp_c); end
    render_we = 1'b0;
    step();
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL wr_idle: got %b want 0", fb_we); end
    render_done = 1'b1;
    step();
    render_done   = 1'b0;
    render_coords = '{x: 9'd10, y: 8'd20};
    render_color  = 3'd5;
    render_we     = 1'b1;
    step();
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL wr_dropped_vblank: got %b want 0", fb_we); end
    render_we = 1'b0;
  endtask

  task automatic test_swap();
    repeat (100) step();
    checks++; if (back_buf !== 1'b0 || frame_count !== 16'd0 || render_ack !== 1'b0) begin errors++; $display("FAIL swap_premature: got bb=%b fc=%0d ack=%b want 0/0/0", back_buf, frame_count, render_ack); end
    vsync = 1'b1;
    step();
    checks++; if (back_buf !== 1'b0 || render_ack !== 1'b0) begin errors++; $display("FAIL swap_state: got bb=%b ack=%b want 0/0", back_buf, render_ack); end
    step();
    checks++; if (back_buf !== 1'b1) begin errors++; $display("FAIL swap_back_buf: got %b want 1", back_buf); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL swap_count: got %0d want 1", frame_count); end
    repeat (CLR_CYC) step();
    checks++; if (render_ack !== 1'b1) begin errors++; $display("FAIL swap_ack: got %b want 1", render_ack); end
    step();
    checks++; if (render_ack !== 1'b0) begin errors++; $display("FAIL swap_ack_single: got %b want 0", render_ack); end
  endtask

  task automatic test_coincident_edge();
    vsync = 1'b0;
    step();
    vsync       = 1'b1;
    render_done = 1'b1;
    step();
    render_done = 1'b0;
    repeat (3) step();
    checks++; if (back_buf !== 1'b1 || frame_count !== 16'd1 || render_ack !== 1'b0) begin errors++; $display("FAIL coinc_no_swap: got bb=%b fc=%0d ack=%b want 1/1/0", back_buf, frame_count, render_ack); end
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
    step();
    checks++; if (back_buf !== 1'b0 || frame_count !== 16'd2) begin errors++; $display("FAIL coinc_next_swap: got bb=%b fc=%0d want 0/2", back_buf, frame_count); end
    repeat (CLR_CYC) step();
    checks++; if (render_ack !== 1'b1) begin errors++; $display("FAIL coinc_ack: got %b want 1", render_ack); end
    step();
  endtask

  task automatic test_count_wrap();
    render_done = 1'b1;
    step();
    render_done = 1'b0;
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
    step();
    checks++; if (frame_count !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h want 0000", frame_count); end
    checks++; if (back_buf !== 1'b1) begin errors++; $display("FAIL wrap_back_buf: got %b want 1", back_buf); end
    repeat (CLR_CYC) step();
    step();
  endtask

  task automatic test_reset_mid_frame();
    render_coords = '{x: 9'd7, y: 8'd8};
    render_color  = 3'd3;
    render_we     = 1'b1;
    step();
    checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL midrst_pre_we: got %b want 1", fb_we); end
    Reset_n = 1'b0;
    #1;
    checks++; if (render_ack !== 1'b0 || fb_we !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got ack=%b we=%b want 0/0", render_ack, fb_we); end
    checks++; if (fb_coords !== 17'h0 || fb_color !== 3'd0) begin errors++; $display("FAIL midrst_fb: got %h/%0d want 0/0", fb_coords, fb_color); end
    checks++; if (back_buf !== 1'b0 || frame_count !== 16'd0) begin errors++; $display("FAIL midrst_buf: got bb=%b fc=%0d want 0/0", back_buf, frame_count); end
    checks++; if (player_pos !== 32'h0 || player_angle !== 8'h0) begin errors++; $display("FAIL midrst_player: got %h/%h want 0/0", player_pos, player_angle); end
    render_we = 1'b0;
    step();
    step();
    checks++; if (back_buf !== 1'b0 || render_ack !== 1'b0) begin errors++; $display("FAIL midrst_held: got bb=%b ack=%b want 0/0", back_buf, render_ack); end
    player_pos_in = pos_a;
    Reset_n = 1'b1;
    step();
    repeat (CLR_CYC) step();
    checks++; if (render_ack !== 1'b1 || player_pos !== pos_a) begin errors++; $display("FAIL midrst_restart: got ack=%b pos=%h want 1/%h", render_ack, player_pos, pos_a); end
  endtask

  initial begin
    test_reset();
    test_kick();
    test_render_writes();
    test_swap();
    test_coincident_edge();
    test_count_wrap();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
